// File: rtl/mux_nto1_scan.sv
// N-channel, W-bit registered multiplexer with direct-select and auto-scan modes.
// Optional per-channel enable mask is built in when MUX_MASK_EN is defined.
`timescale 1ns/1ps

module mux_nto1_scan #(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int SW    = 2,
  parameter int DWELL = 4
) (
  input  logic           CLK,
  input  logic           CLR_n,
  input  logic [N*W-1:0] D,
  input  logic [SW-1:0]  S,
  input  logic           MODE,
  input  logic           HOLD,
`ifdef MUX_MASK_EN
  input  logic [N-1:0]   EN,
`endif
  output logic [W-1:0]   Y,
  output logic [SW-1:0]  CH,
  output logic           STEP
);

  localparam int            CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [SW-1:0] CH_LAST  = SW'(N - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          mode_q;
  logic [SW-1:0] ch_next;
  logic [SW-1:0] ch_adv;
  logic [SW-1:0] cand;
  logic          found;
  logic [W-1:0]  y_next;
  logic          step_next;
  logic [N-1:0]  en_eff;
  logic          any_en;
  logic [W-1:0]  chan [N];

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign chan[k] = D[k*W +: W];
  end

`ifdef MUX_MASK_EN
  assign en_eff = EN;
`else
  assign en_eff = '1;
`endif
  assign any_en = |en_eff;

  // Next enabled channel above CH with wrap; lands back on CH when it is the only one enabled
  always_comb begin
    ch_adv = CH;
    cand   = CH;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = (cand == CH_LAST) ? '0 : cand + 1'b1;
      if (!found && en_eff[cand]) begin
        ch_adv = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    ch_next   = CH;
    cnt_next  = cnt;
    y_next    = Y;
    step_next = 1'b0;
    if (HOLD) begin
      ch_next  = CH;
      cnt_next = cnt;
      y_next   = Y;
    end else if (!MODE) begin
      cnt_next = '0;
      if (32'(S) < 32'(N)) begin
        ch_next = S;
      end
      y_next = en_eff[ch_next] ? chan[ch_next] : '0;
    end else begin
      // A fresh entry into scan mode always begins with a full dwell on the current channel
      if (MODE != mode_q) begin
        cnt_next = '0;
      end else if (cnt == CNT_LAST) begin
        cnt_next = '0;
        if (any_en) begin
          ch_next   = ch_adv;
          step_next = 1'b1;
        end
      end else begin
        cnt_next = cnt + 1'b1;
      end
      y_next = any_en ? chan[ch_next] : '0;
    end
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      Y      <= '0;
      CH     <= '0;
      STEP   <= 1'b0;
      cnt    <= '0;
      mode_q <= 1'b0;
    end else begin
      Y    <= y_next;
      CH   <= ch_next;
      STEP <= step_next;
      cnt  <= cnt_next;
      if (!HOLD) begin
        mode_q <= MODE;
      end
    end
  end

endmodule
